// File: rtl/serial_pattern_detector_if.sv
// Bundles the serial-bit inputs and the detector status outputs of serial_pattern_detector.
// The master drives the bit stream; the slave is the detector.
interface serial_pattern_detector_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             din;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             sat;
  logic             primed;

  modport master (
    output en, din, clr,
    input  match, match_count, sat, primed
  );

  modport slave (
    input  en, din, clr,
    output match, match_count, sat, primed
  );
endinterface

// File: rtl/serial_pattern_detector.sv
// Overlapping fixed-pattern detector on a qualified serial bit stream, with a fill
// state machine, a registered match pulse and a saturating match counter.
module serial_pattern_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_pattern_detector_if.slave bus
);

  localparam int FILL_W = $clog2(PATTERN_LEN + 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    PRIMED
  } state_t;

  state_t                 state, state_nxt;
  logic [FILL_W-1:0]      fill, fill_nxt;
  logic [PATTERN_LEN-1:0] hist, hist_nxt;
  logic [CNT_W-1:0]       count, count_nxt;
  logic                   sat_q, sat_nxt;
  logic                   match_q, match_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Fill tracking: fill holds the number of bits taken while FILLING.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    if (bus.clr) begin
      state_nxt = EMPTY;
      fill_nxt  = '0;
    end else if (bus.en) begin
      unique case (state)
        EMPTY: begin
          state_nxt = FILLING;
          fill_nxt  = FILL_W'(1);
        end
        FILLING: begin
          fill_nxt = fill + 1'b1;
          if (fill == FILL_W'(PATTERN_LEN - 1)) state_nxt = PRIMED;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // A match needs a full window, so the zeroed history can never false-match.
  always_comb begin
    hist_nxt  = hist;
    count_nxt = count;
    sat_nxt   = sat_q;
    match_nxt = 1'b0;
    if (bus.clr) begin
      hist_nxt  = '0;
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (bus.en) begin
      hist_nxt = {hist[PATTERN_LEN-2:0], bus.din};
      if (state_nxt == PRIMED && hist_nxt == PATTERN) begin
        match_nxt = 1'b1;
        count_nxt = sat_inc(count);
        sat_nxt   = sat_q | (&count_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      fill    <= '0;
      hist    <= '0;
      count   <= '0;
      sat_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      fill    <= fill_nxt;
      hist    <= hist_nxt;
      count   <= count_nxt;
      sat_q   <= sat_nxt;
      match_q <= match_nxt;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = count;
  assign bus.sat         = sat_q;
  assign bus.primed      = (state == PRIMED);

endmodule
